// File: rtl/mem_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mem_ctrl_pkg : shared types and tables for the data memory controller
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mem_ctrl_pkg;

  localparam logic [15:0] SP_RESET_DEFAULT    = 16'd2043;
  localparam logic [15:0] STACK_LIMIT_DEFAULT = 16'd1024;

  typedef enum logic [2:0] {
    OP_PUSH = 3'd0,
    OP_POP  = 3'd1,
    OP_CALL = 3'd2,
    OP_RET  = 3'd3,
    OP_INT  = 3'd4,
    OP_RTI  = 3'd5
  } stk_op_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PUSH_SEQ = 2'd1,
    ST_POP_SEQ  = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

  function automatic logic [1:0] beat_count(input logic [2:0] op);
    case (op)
      OP_PUSH, OP_POP: beat_count = 2'd1;
      OP_CALL, OP_RET: beat_count = 2'd2;
      OP_INT,  OP_RTI: beat_count = 2'd3;
      default:         beat_count = 2'd0;
    endcase
  endfunction

  function automatic logic op_is_push(input logic [2:0] op);
    op_is_push = (op == OP_PUSH) || (op == OP_CALL) || (op == OP_INT);
  endfunction

  function automatic logic op_is_pop(input logic [2:0] op);
    op_is_pop = (op == OP_POP) || (op == OP_RET) || (op == OP_RTI);
  endfunction

endpackage

`default_nettype wire

// File: rtl/data_mem_ctrl_if.sv
// ---------------------------------------------------------------------------
// data_mem_ctrl_if : load/store, stack-op and memory signals of the controller
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface data_mem_ctrl_if;
  logic        ls_req;
  logic        ls_we;
  logic [15:0] ls_addr;
  logic [15:0] ls_wdata;
  logic        ls_gnt;
  logic [15:0] ls_rdata;

  logic        stk_req;
  logic [2:0]  stk_op;
  logic [15:0] stk_wdata;
  logic [31:0] stk_pc;
  logic [15:0] stk_flags;
  logic [15:0] stk_rdata;
  logic [31:0] stk_pc_out;
  logic [15:0] stk_flags_out;
  logic        stk_done;
  logic        stk_err;
  logic        busy;
  logic [15:0] sp;

  logic        mem_re;
  logic        mem_we;
  logic [15:0] mem_raddr;
  logic [15:0] mem_waddr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  modport slave (
    input  ls_req, ls_we, ls_addr, ls_wdata,
    input  stk_req, stk_op, stk_wdata, stk_pc, stk_flags,
    input  mem_rdata,
    output ls_gnt, ls_rdata,
    output stk_rdata, stk_pc_out, stk_flags_out, stk_done, stk_err, busy, sp,
    output mem_re, mem_we, mem_raddr, mem_waddr, mem_wdata
  );

  modport master (
    output ls_req, ls_we, ls_addr, ls_wdata,
    output stk_req, stk_op, stk_wdata, stk_pc, stk_flags,
    output mem_rdata,
    input  ls_gnt, ls_rdata,
    input  stk_rdata, stk_pc_out, stk_flags_out, stk_done, stk_err, busy, sp,
    input  mem_re, mem_we, mem_raddr, mem_waddr, mem_wdata
  );
endinterface

`default_nettype wire

// File: rtl/stack_ptr_unit.sv
// ---------------------------------------------------------------------------
// stack_ptr_unit : stack pointer register with empty / limit detection
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module stack_ptr_unit
  import mem_ctrl_pkg::*;
#(
  parameter logic [15:0] SP_RESET    = SP_RESET_DEFAULT,
  parameter logic [15:0] STACK_LIMIT = STACK_LIMIT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        dec,
  output logic [15:0] sp,
  output logic        empty,
  output logic        at_limit
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp <= SP_RESET;
    end else if (dec) begin
      sp <= sp - 16'd1;
    end else if (inc) begin
      sp <= sp + 16'd1;
    end
  end

  assign empty    = (sp == SP_RESET);
  assign at_limit = (sp == STACK_LIMIT);

endmodule

`default_nettype wire

// File: rtl/data_mem_ctrl.sv
// ---------------------------------------------------------------------------
// data_mem_ctrl : arbitrates the data memory between load/store and stack ops
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module data_mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter logic [15:0] SP_RESET    = SP_RESET_DEFAULT,
  parameter logic [15:0] STACK_LIMIT = STACK_LIMIT_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  data_mem_ctrl_if.slave  bus
);

  state_t      state;
  logic [1:0]  beat;
  logic [2:0]  op_q;
  logic [15:0] wdata_q;
  logic [31:0] pc_q;
  logic [15:0] flags_q;
  logic [15:0] rdata_q;
  logic [31:0] pc_out_q;
  logic [15:0] flags_out_q;
  logic        done_q;
  logic        err_q;

  logic [15:0] sp;
  logic        sp_empty;
  logic        sp_at_limit;
  logic        sp_inc;
  logic        sp_dec;
  logic [1:0]  last_beat;
  logic        ls_gnt;
  logic [15:0] push_word;

  stack_ptr_unit #(
    .SP_RESET    (SP_RESET),
    .STACK_LIMIT (STACK_LIMIT)
  ) u_sp (
    .clk      (clk),
    .rst      (rst),
    .inc      (sp_inc),
    .dec      (sp_dec),
    .sp       (sp),
    .empty    (sp_empty),
    .at_limit (sp_at_limit)
  );

  assign last_beat = beat_count(op_q) - 2'd1;
  assign ls_gnt    = bus.ls_req & (state == ST_IDLE) & ~bus.stk_req;

  // Push word order puts the PC high half deepest so pops come back low-first.
  always_comb begin
    push_word = wdata_q;
    case (op_q)
      OP_CALL: push_word = (beat == 2'd0) ? pc_q[31:16] : pc_q[15:0];
      OP_INT: begin
        case (beat)
          2'd0:    push_word = pc_q[31:16];
          2'd1:    push_word = pc_q[15:0];
          default: push_word = flags_q;
        endcase
      end
      default: push_word = wdata_q;
    endcase
  end

  always_comb begin
    bus.mem_re    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_raddr = 16'd0;
    bus.mem_waddr = 16'd0;
    bus.mem_wdata = 16'd0;
    sp_inc        = 1'b0;
    sp_dec        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ls_gnt) begin
          if (bus.ls_we) begin
            bus.mem_we    = 1'b1;
            bus.mem_waddr = bus.ls_addr;
            bus.mem_wdata = bus.ls_wdata;
          end else begin
            bus.mem_re    = 1'b1;
            bus.mem_raddr = bus.ls_addr;
          end
        end
      end
      ST_PUSH_SEQ: begin
        if (!sp_at_limit) begin
          bus.mem_we    = 1'b1;
          bus.mem_waddr = sp;
          bus.mem_wdata = push_word;
          sp_dec        = 1'b1;
        end
      end
      ST_POP_SEQ: begin
        if (!sp_empty) begin
          bus.mem_re    = 1'b1;
          bus.mem_raddr = sp + 16'd1;
          sp_inc        = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      beat        <= 2'd0;
      op_q        <= 3'd0;
      wdata_q     <= 16'd0;
      pc_q        <= 32'd0;
      flags_q     <= 16'd0;
      rdata_q     <= 16'd0;
      pc_out_q    <= 32'd0;
      flags_out_q <= 16'd0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.stk_req) begin
            op_q        <= bus.stk_op;
            wdata_q     <= bus.stk_wdata;
            pc_q        <= bus.stk_pc;
            flags_q     <= bus.stk_flags;
            beat        <= 2'd0;
            rdata_q     <= 16'd0;
            pc_out_q    <= 32'd0;
            flags_out_q <= 16'd0;
            err_q       <= 1'b0;
            if (op_is_push(bus.stk_op)) begin
              state <= ST_PUSH_SEQ;
            end else if (op_is_pop(bus.stk_op)) begin
              state <= ST_POP_SEQ;
            end else begin
              state  <= ST_DONE;
              done_q <= 1'b1;
              err_q  <= 1'b1;
            end
          end
        end
        ST_PUSH_SEQ: begin
          if (sp_at_limit) begin
            state  <= ST_DONE;
            done_q <= 1'b1;
            err_q  <= 1'b1;
          end else if (beat == last_beat) begin
            state  <= ST_DONE;
            done_q <= 1'b1;
          end else begin
            beat <= beat + 2'd1;
          end
        end
        ST_POP_SEQ: begin
          if (sp_empty) begin
            state       <= ST_DONE;
            done_q      <= 1'b1;
            err_q       <= 1'b1;
            rdata_q     <= 16'd0;
            pc_out_q    <= 32'd0;
            flags_out_q <= 16'd0;
          end else begin
            case (op_q)
              OP_POP: rdata_q <= bus.mem_rdata;
              OP_RET: begin
                if (beat == 2'd0) pc_out_q[15:0]  <= bus.mem_rdata;
                else              pc_out_q[31:16] <= bus.mem_rdata;
              end
              OP_RTI: begin
                case (beat)
                  2'd0:    flags_out_q     <= bus.mem_rdata;
                  2'd1:    pc_out_q[15:0]  <= bus.mem_rdata;
                  default: pc_out_q[31:16] <= bus.mem_rdata;
                endcase
              end
              default: ;
            endcase
            if (beat == last_beat) begin
              state  <= ST_DONE;
              done_q <= 1'b1;
            end else begin
              beat <= beat + 2'd1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          err_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ls_gnt        = ls_gnt;
  assign bus.ls_rdata      = (ls_gnt & ~bus.ls_we) ? bus.mem_rdata : 16'd0;
  assign bus.stk_rdata     = rdata_q;
  assign bus.stk_pc_out    = pc_out_q;
  assign bus.stk_flags_out = flags_out_q;
  assign bus.stk_done      = done_q;
  assign bus.stk_err       = err_q;
  assign bus.busy          = (state != ST_IDLE);
  assign bus.sp            = sp;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_data_mem_ctrl : directed + randomized checks of data_mem_ctrl against a word-stack model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_data_mem_ctrl;

  localparam int SPR = 2043;
  localparam int LIM = 1024;

  logic clk;
  logic rst;
  data_mem_ctrl_if bus();

  data_mem_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [15:0] mem     [0:2047];
  logic [15:0] exp_mem [0:2047];
  int m_sp;
  int vectors;
  int miscompares;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.mem_rdata = mem[bus.mem_raddr[10:0]];
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_waddr[10:0]] <= bus.mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ls_access(input bit we, input logic [15:0] addr, input logic [15:0] d);
    bus.ls_req   = 1'b1;
    bus.ls_we    = we;
    bus.ls_addr  = addr;
    bus.ls_wdata = d;
    #1;
    chk("ls_gnt", {31'd0, bus.ls_gnt}, 32'd1);
    if (we) chk("ls_mem_we", {31'd0, bus.mem_we}, 32'd1);
    else    chk("ls_rdata", {16'd0, bus.ls_rdata}, {16'd0, exp_mem[addr[10:0]]});
    tick();
    if (we) begin
      exp_mem[addr[10:0]] = d;
      chk("ls_store_mem", {16'd0, mem[addr[10:0]]}, {16'd0, d});
    end
    bus.ls_req = 1'b0;
    bus.ls_we  = 1'b0;
  endtask

  // Model: a word stack in exp_mem addressed by m_sp (next free slot, grows down).
  task automatic stack_op(input logic [2:0] op, input logic [15:0] wd,
                          input logic [31:0] pc, input logic [15:0] fl);
    logic [15:0] words[$];
    logic [15:0] popped[$];
    int          waddrs[$];
    int          attempted;
    int          n;
    int          cyc;
    bit          err;
    logic [31:0] e_pc;
    logic [15:0] e_fl;
    logic [15:0] e_rd;
    attempted = 0; err = 0; e_pc = 0; e_fl = 0; e_rd = 0;
    if (op == 3'd0 || op == 3'd2 || op == 3'd4) begin
      if (op == 3'd0) words.push_back(wd);
      else begin
        words.push_back(pc[31:16]);
        words.push_back(pc[15:0]);
        if (op == 3'd4) words.push_back(fl);
      end
      for (int i = 0; i < words.size(); i++) begin
        attempted++;
        if (m_sp == LIM) begin err = 1; break; end
        exp_mem[m_sp] = words[i];
        waddrs.push_back(m_sp);
        m_sp--;
      end
    end else if (op == 3'd1 || op == 3'd3 || op == 3'd5) begin
      n = (op == 3'd1) ? 1 : (op == 3'd3) ? 2 : 3;
      for (int i = 0; i < n; i++) begin
        attempted++;
        if (m_sp == SPR) begin err = 1; break; end
        m_sp++;
        popped.push_back(exp_mem[m_sp]);
      end
      if (!err) begin
        if (op == 3'd1) e_rd = popped[0];
        if (op == 3'd3) e_pc = {popped[1], popped[0]};
        if (op == 3'd5) begin e_fl = popped[0]; e_pc = {popped[2], popped[1]}; end
      end
    end else begin
      err = 1;
    end

    bus.stk_req   = 1'b1;
    bus.stk_op    = op;
    bus.stk_wdata = wd;
    bus.stk_pc    = pc;
    bus.stk_flags = fl;
    #1;
    chk("ls_gnt_arb", {31'd0, bus.ls_gnt}, 32'd0);
    tick();
    cyc = 1;
    while (!bus.stk_done && cyc < 8) begin
      chk("busy_seq", {31'd0, bus.busy}, 32'd1);
      chk("ls_gnt_stall", {31'd0, bus.ls_gnt}, 32'd0);
      tick();
      cyc++;
    end
    chk("stk_done", {31'd0, bus.stk_done}, 32'd1);
    chk("done_cycle", cyc, attempted + 1);
    chk("busy_done", {31'd0, bus.busy}, 32'd1);
    chk("stk_err", {31'd0, bus.stk_err}, {31'd0, err});
    chk("sp", {16'd0, bus.sp}, m_sp);
    if (op == 3'd1) chk("stk_rdata", {16'd0, bus.stk_rdata}, {16'd0, e_rd});
    if (op == 3'd3 || op == 3'd5) chk("stk_pc_out", bus.stk_pc_out, e_pc);
    if (op == 3'd5) chk("stk_flags_out", {16'd0, bus.stk_flags_out}, {16'd0, e_fl});
    bus.stk_req = 1'b0;
    tick();
    chk("busy_after", {31'd0, bus.busy}, 32'd0);
    chk("done_pulse", {31'd0, bus.stk_done}, 32'd0);
    foreach (waddrs[i]) chk("push_mem", {16'd0, mem[waddrs[i]]}, {16'd0, exp_mem[waddrs[i]]});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vectors = 0; miscompares = 0;
    for (int i = 0; i < 2048; i++) begin mem[i] = 16'd0; exp_mem[i] = 16'd0; end
    rst = 1'b1;
    bus.ls_req = 0; bus.ls_we = 0; bus.ls_addr = 0; bus.ls_wdata = 0;
    bus.stk_req = 0; bus.stk_op = 0; bus.stk_wdata = 0; bus.stk_pc = 0; bus.stk_flags = 0;
    m_sp = SPR;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_sp", {16'd0, bus.sp}, SPR);
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    chk("reset_mem_we", {31'd0, bus.mem_we}, 32'd0);
    chk("reset_done", {31'd0, bus.stk_done}, 32'd0);
    rst = 1'b0;
    tick();

    ls_access(1'b1, 16'h0010, 16'h00A5);
    ls_access(1'b0, 16'h0010, 16'h0000);

    stack_op(3'd2, 16'd0, 32'h0001_2345, 16'd0);
    chk("call_mem_hi", {16'd0, mem[2043]}, 32'h0001);
    chk("call_mem_lo", {16'd0, mem[2042]}, 32'h2345);
    stack_op(3'd3, 16'd0, 32'd0, 16'd0);
    chk("ret_pc_const", bus.stk_pc_out, 32'h0001_2345);

    stack_op(3'd4, 16'd0, 32'hABCD_0004, 16'h000B);
    chk("int_sp_const", {16'd0, bus.sp}, 32'd2040);
    stack_op(3'd5, 16'd0, 32'd0, 16'd0);
    chk("rti_flags_const", {16'd0, bus.stk_flags_out}, 32'h000B);

    bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_addr = 16'h0010;
    stack_op(3'd0, 16'($urandom), 32'd0, 16'd0);
    ls_access(1'b0, 16'h0010, 16'h0000);
    stack_op(3'd1, 16'd0, 32'd0, 16'd0);

    stack_op(3'd1, 16'd0, 32'd0, 16'd0);
    chk("underflow_sp_const", {16'd0, bus.sp}, SPR);
    stack_op(3'd7, 16'd0, 32'd0, 16'd0);
    stack_op(3'd6, 16'd0, 32'd0, 16'd0);

    for (int i = 0; i < 20; i++)
      ls_access(1'($urandom), 16'($urandom_range(0, 1023)), 16'($urandom));

    while (m_sp != LIM) begin
      stack_op(3'($urandom_range(0, 2) * 2), 16'($urandom), $urandom, 16'($urandom));
      if ($urandom_range(0, 7) == 0)
        ls_access(1'($urandom), 16'($urandom_range(0, 1023)), 16'($urandom));
    end
    stack_op(3'd0, 16'h5A5A, 32'd0, 16'd0);
    chk("overflow_sp_const", {16'd0, bus.sp}, LIM);

    while (m_sp != SPR) begin
      stack_op(3'($urandom_range(0, 2) * 2 + 1), 16'd0, 32'd0, 16'd0);
    end
    stack_op(3'd5, 16'd0, 32'd0, 16'd0);

    bus.stk_req = 1'b1; bus.stk_op = 3'd4; bus.stk_pc = 32'h1357_9BDF; bus.stk_flags = 16'h00FF;
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("rst_mid_sp", {16'd0, bus.sp}, SPR);
    chk("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_mid_done", {31'd0, bus.stk_done}, 32'd0);
    chk("rst_mid_mem_we", {31'd0, bus.mem_we}, 32'd0);
    bus.stk_req = 1'b0;
    tick();
    rst = 1'b0;
    exp_mem[2043] = 16'h1357;
    m_sp = SPR;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_done", {31'd0, bus.stk_done}, 32'd0);
    end
    chk("rst_kept_word", {16'd0, mem[2043]}, {16'd0, exp_mem[2043]});
    chk("rst_no_beat2", {16'd0, mem[2042]}, {16'd0, exp_mem[2042]});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
